// File: rtl/tcls_recovery_pkg.sv
// ---------------------------------------------------------------------------
// tcls_recovery_pkg
// Shared definitions for the TCLS resynchronisation controller.
//   recovery_state_e : FSM state encoding as seen by software in the status
//                      register (state_o).
//   St*              : the same encodings as plain 3-bit constants, used as
//                      the FSM state values inside the controller.
// ---------------------------------------------------------------------------
package tcls_recovery_pkg;

    typedef enum logic [2:0] {
        RecIdle    = 3'd0,
        RecUnload  = 3'd1,
        RecSetback = 3'd2,
        RecReload  = 3'd3,
        RecFatal   = 3'd4
    } recovery_state_e;

    localparam logic [2:0] StIdle    = RecIdle;
    localparam logic [2:0] StUnload  = RecUnload;
    localparam logic [2:0] StSetback = RecSetback;
    localparam logic [2:0] StReload  = RecReload;
    localparam logic [2:0] StFatal   = RecFatal;

endpackage

// File: rtl/tcls_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// tcls_recovery_ctrl
// Sequences the TCLS resynchronisation flow around the lock-step voter:
// raises the recovery IRQ, follows the software unload/reload handshake,
// applies core setback pulses, bounds each phase with a watchdog, retries
// failed recoveries and escalates to FATAL.
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   enable_i        cluster fetch enable; low forces IDLE, clears retries
//   resynch_req_i   voter mismatch while cores run (level)
//   force_i         software-forced resynch (1-cycle pulse)
//   mismatch_i      single-core mismatch, checked during RELOAD (level)
//   setback_en_i    apply setback between UNLOAD and RELOAD
//   unload_done_i   state pointer written non-zero (1-cycle pulse)
//   reload_done_i   state pointer written zero (1-cycle pulse)
//   recovery_irq_o  recovery interrupt, high while in UNLOAD
//   setback_o       core setback, high while in SETBACK
//   busy_o          state != IDLE
//   fatal_o         unrecoverable; held until enable_i drops
//   recovered_o     1-cycle pulse after a successful reload
//   state_o         encoded FSM state
//   retry_cnt_o     retries used in this recovery, saturating at 3
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | cores running in lock-step, waiting for a resynch request
// UNLOAD  | IRQ raised, cores storing their state
// SETBACK | setback held for SetbackCycles cycles
// RELOAD  | cores restoring state, watching for renewed mismatch
// FATAL   | retries exhausted, waits for enable_i low
// ---------------------------------------------------------------------------
module tcls_recovery_ctrl
    import tcls_recovery_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned SetbackCycles = 4,
    parameter int unsigned MaxRetries    = 3,
    parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       resynch_req_i,
    input  logic       force_i,
    input  logic       mismatch_i,
    input  logic       setback_en_i,
    input  logic       unload_done_i,
    input  logic       reload_done_i,
    output logic       recovery_irq_o,
    output logic       setback_o,
    output logic       busy_o,
    output logic       fatal_o,
    output logic       recovered_o,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt_o
);

    localparam int unsigned RetryWidth = $clog2(MaxRetries + 1);

    logic [2:0]            state_q, state_d;
    logic [CntWidth-1:0]   timer_q, timer_d;
    logic [RetryWidth-1:0] retry_q, retry_d;
    // Separate 2-bit saturating copy so the status field is independent of
    // how large MaxRetries is configured.
    logic [1:0]            retry_sat_q, retry_sat_d;
    logic                  recovered_d;
    logic                  retry_event;
    logic                  phase_timeout;
    logic                  setback_last;
    logic                  irq_q, setback_q, fatal_q, recovered_q;

    assign phase_timeout = (timer_q == CntWidth'(TimeoutCycles - 1));
    assign setback_last  = (timer_q == CntWidth'(SetbackCycles - 1));

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        retry_sat_d = retry_sat_q;
        recovered_d = 1'b0;
        retry_event = 1'b0;

        case (state_q)
            StIdle: begin
                if (resynch_req_i || force_i) state_d = StUnload;
            end
            StUnload: begin
                if (unload_done_i)      state_d = setback_en_i ? StSetback : StReload;
                else if (phase_timeout) retry_event = 1'b1;
            end
            StSetback: begin
                if (setback_last) state_d = StReload;
            end
            StReload: begin
                if (reload_done_i) begin
                    state_d     = StIdle;
                    recovered_d = 1'b1;
                    retry_d     = '0;
                    retry_sat_d = '0;
                end else if (mismatch_i || phase_timeout) begin
                    retry_event = 1'b1;
                end
            end
            StFatal: ;
            default: state_d = StIdle;
        endcase

        // A retry always goes through SETBACK, even with setback disabled,
        // so the cores restart from a known point.
        if (retry_event) begin
            if (retry_q == RetryWidth'(MaxRetries)) begin
                state_d = StFatal;
            end else begin
                retry_d = retry_q + RetryWidth'(1);
                if (retry_sat_q != 2'd3) retry_sat_d = retry_sat_q + 2'd1;
                state_d = StSetback;
            end
        end

        if (!enable_i) begin
            state_d     = StIdle;
            retry_d     = '0;
            retry_sat_d = '0;
            recovered_d = 1'b0;
        end
    end

    // Every state change restarts the phase timer; the limits above always
    // force a state change, so the counter cannot wrap.
    always_comb begin
        timer_d = '0;
        if ((state_d == state_q) &&
            ((state_q == StUnload) || (state_q == StSetback) || (state_q == StReload))) begin
            timer_d = timer_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            retry_q     <= '0;
            retry_sat_q <= '0;
            irq_q       <= 1'b0;
            setback_q   <= 1'b0;
            fatal_q     <= 1'b0;
            recovered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            retry_sat_q <= retry_sat_d;
            irq_q       <= (state_d == StUnload);
            setback_q   <= (state_d == StSetback);
            fatal_q     <= (state_d == StFatal);
            recovered_q <= recovered_d;
        end
    end

    assign recovery_irq_o = irq_q;
    assign setback_o      = setback_q;
    assign fatal_o        = fatal_q;
    assign recovered_o    = recovered_q;
    assign busy_o         = (state_q != StIdle);
    assign state_o        = state_q;
    assign retry_cnt_o    = retry_sat_q;

endmodule

// File: tb/tb_tcls_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tcls_recovery_ctrl
// Directed recovery scenarios with randomised timing, followed by a random
// soak. Every cycle the full output vector is compared against a reference
// model that tracks the phase, cycles spent in the phase and retries used.
// ---------------------------------------------------------------------------
module tb_tcls_recovery_ctrl;

    localparam int TO = 1024;
    localparam int SB = 4;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, req = 1'b0, frc = 1'b0, mm = 1'b0;
    logic       sb_en = 1'b0, ud = 1'b0, rd = 1'b0;
    logic       irq, setback, busy, fatal, recovered;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    tcls_recovery_ctrl #(
        .TimeoutCycles (TO),
        .SetbackCycles (SB),
        .MaxRetries    (MR)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (en),
        .resynch_req_i  (req),
        .force_i        (frc),
        .mismatch_i     (mm),
        .setback_en_i   (sb_en),
        .unload_done_i  (ud),
        .reload_done_i  (rd),
        .recovery_irq_o (irq),
        .setback_o      (setback),
        .busy_o         (busy),
        .fatal_o        (fatal),
        .recovered_o    (recovered),
        .state_o        (state),
        .retry_cnt_o    (retry_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase uses the software-visible encoding
    // (0 idle, 1 unload, 2 setback, 3 reload, 4 fatal).
    int m_phase = 0;
    int m_age   = 0;
    int m_retry = 0;
    int m_rec   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp_outs();
        int rc;
        logic [9:0] v;
        rc = (m_retry > 3) ? 3 : m_retry;
        v = {3'(m_phase), 2'(rc), (m_phase == 1), (m_phase == 2), (m_phase != 0),
             (m_phase == 4), (m_rec != 0)};
        return v;
    endfunction

    task automatic model_step();
        int  nxt;
        bit  retry_hit;
        m_rec = 0;
        if (!en) begin
            m_phase = 0;
            m_age   = 0;
            m_retry = 0;
            return;
        end
        nxt       = m_phase;
        retry_hit = 0;
        case (m_phase)
            0: if (req || frc) nxt = 1;
            1: begin
                if (ud) nxt = sb_en ? 2 : 3;
                else if (m_age + 1 >= TO) retry_hit = 1;
            end
            2: if (m_age + 1 >= SB) nxt = 3;
            3: begin
                if (rd) begin
                    nxt     = 0;
                    m_rec   = 1;
                    m_retry = 0;
                end else if (mm || (m_age + 1 >= TO)) begin
                    retry_hit = 1;
                end
            end
            default: ;
        endcase
        if (retry_hit) begin
            if (m_retry >= MR) nxt = 4;
            else begin
                m_retry++;
                nxt = 2;
            end
        end
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("outs", 32'({state, retry_cnt, irq, setback, busy, fatal, recovered}),
                 32'(exp_outs()));
        req = 1'b0;
        frc = 1'b0;
        ud  = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int phase, input int budget, input string tag);
        for (int i = 0; i < budget && m_phase != phase; i++) tick();
        check_eq(tag, 32'(state), 32'(phase));
    endtask

    initial begin
        // Reset
        @(negedge clk);
        check_eq("rst_outs", 32'({state, retry_cnt, irq, setback, busy, fatal, recovered}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        check_eq("rst_release", 32'({state, retry_cnt, irq, setback, busy, fatal, recovered}), 32'd0);

        // 1. Clean recovery with setback
        sb_en = 1'b1;
        idle_ticks($urandom_range(1, 5));
        req = 1'b1;
        tick();
        check_eq("s1_irq", 32'(irq), 32'd1);
        idle_ticks(9);
        ud = 1'b1;
        tick();
        for (int i = 0; i < SB; i++) begin
            check_eq("s1_setback", 32'(setback), 32'd1);
            tick();
        end
        check_eq("s1_reload", 32'(state), 32'd3);
        check_eq("s1_sb_off", 32'(setback), 32'd0);
        idle_ticks($urandom_range(0, 20));
        rd = 1'b1;
        tick();
        check_eq("s1_recovered", 32'(recovered), 32'd1);
        check_eq("s1_retry", 32'(retry_cnt), 32'd0);
        tick();
        check_eq("s1_rec_pulse", 32'(recovered), 32'd0);

        // 2. Setback disabled: UNLOAD goes straight to RELOAD
        sb_en = 1'b0;
        frc = 1'b1;
        tick();
        idle_ticks($urandom_range(0, 30));
        ud = 1'b1;
        tick();
        check_eq("s2_reload", 32'(state), 32'd3);
        check_eq("s2_no_setback", 32'(setback), 32'd0);
        rd = 1'b1;
        tick();
        check_eq("s2_idle", 32'(state), 32'd0);

        // 3. Watchdog timeouts escalate to FATAL
        sb_en = 1'b1;
        req = 1'b1;
        tick();
        run_until(2, TO + 2, "s3_to_setback");
        check_eq("s3_retry1", 32'(retry_cnt), 32'd1);
        run_until(4, 4 * (TO + SB) + 8, "s3_fatal_state");
        check_eq("s3_fatal", 32'(fatal), 32'd1);
        check_eq("s3_retry3", 32'(retry_cnt), 32'd3);
        frc = 1'b1;
        req = 1'b1;
        tick();
        check_eq("s3_fatal_hold", 32'(state), 32'd4);

        // 5b. Drop enable in FATAL
        en = 1'b0;
        tick();
        check_eq("s5_fatal_clr", 32'({state, fatal, retry_cnt}), 32'd0);
        en = 1'b1;
        tick();

        // 4. Mismatch in RELOAD, then mismatch together with done
        sb_en = 1'b0;
        req = 1'b1;
        tick();
        ud = 1'b1;
        tick();
        idle_ticks($urandom_range(0, 10));
        mm = 1'b1;
        tick();
        mm = 1'b0;
        check_eq("s4_setback", 32'(state), 32'd2);
        check_eq("s4_retry1", 32'(retry_cnt), 32'd1);
        idle_ticks(SB);
        check_eq("s4_reload", 32'(state), 32'd3);
        mm = 1'b1;
        rd = 1'b1;
        tick();
        mm = 1'b0;
        check_eq("s4_done_wins", 32'(state), 32'd0);
        check_eq("s4_recovered", 32'(recovered), 32'd1);

        // 5a. Drop enable mid-SETBACK with a retry outstanding
        req = 1'b1;
        tick();
        ud = 1'b1;
        tick();
        mm = 1'b1;
        tick();
        mm = 1'b0;
        tick();
        en = 1'b0;
        tick();
        check_eq("s5_abort", 32'({state, setback, fatal, retry_cnt}), 32'd0);
        en = 1'b1;
        tick();

        // 6. force ignored outside IDLE, accepted in IDLE
        req = 1'b1;
        tick();
        idle_ticks(3);
        frc = 1'b1;
        tick();
        check_eq("s6_force_ign", 32'(state), 32'd1);
        ud = 1'b1;
        tick();
        rd = 1'b1;
        tick();
        frc = 1'b1;
        tick();
        check_eq("s6_force_idle", 32'(state), 32'd1);
        en = 1'b0;
        tick();
        en = 1'b1;

        // Random soak
        for (int i = 0; i < 4000; i++) begin
            en    = ($urandom_range(0, 99) != 0);
            req   = ($urandom_range(0, 15) == 0);
            frc   = ($urandom_range(0, 31) == 0);
            mm    = ($urandom_range(0, 39) == 0);
            ud    = ($urandom_range(0, 11) == 0);
            rd    = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 63) == 0) sb_en = ~sb_en;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
